// File: rtl/line_buffer_win2x2.sv
// Streaming 2x2 sliding-window generator over a raster pixel stream, one stored row.
// Optional LINE_BUFFER_ZERO_PAD_EN: emit a window for every pixel, out-of-image taps read 0.
module line_buffer_win2x2 #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tstart,
   input  logic              v0,
   output logic              v1,
   input  logic [DATA_W-1:0] v2,
   output logic              v3,
   output logic [DATA_W-1:0] v4 [0:1][0:1]
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              v3_q, v3_d;
   logic [DATA_W-1:0] win_q [0:1][0:1];
   logic [DATA_W-1:0] win_d [0:1][0:1];
   logic [DATA_W-1:0] mem_q [0:IMG_W-1];
   logic [DATA_W-1:0] above;
   logic              accept, last_col, last_row;

   // Handshake: a pixel is taken on a rising edge where v0 && v1; v1 is high only in RUN.
   assign v1       = (state_q == RUN);
   assign accept   = v0 && (state_q == RUN);
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_row = (row_q == RW'(IMG_H - 1));
   assign above    = mem_q[col_q];
   assign v3       = v3_q;
   assign v4       = win_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (tstart) state_d = RUN;
         RUN:  if (accept && last_col && last_row) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (state_q == IDLE && tstart) begin
         col_d = '0;
         row_d = '0;
      end else if (accept) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_comb begin
      win_d = win_q;
      v3_d  = 1'b0;
      if (accept) begin
         win_d[0][1] = above;
         win_d[1][1] = v2;
`ifdef LINE_BUFFER_ZERO_PAD_EN
         win_d[0][0] = (col_q == '0) ? '0 : win_q[0][1];
         win_d[1][0] = (col_q == '0) ? '0 : win_q[1][1];
         if (row_q == '0) win_d[0][1] = '0;
         v3_d = 1'b1;
`else
         win_d[0][0] = win_q[0][1];
         win_d[1][0] = win_q[1][1];
         // col 0 still shifts, but its window would straddle the row wrap
         v3_d = (row_q != '0) && (col_q != '0);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         v3_q    <= 1'b0;
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
               win_q[r][c] <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         v3_q    <= v3_d;
         win_q   <= win_d;
      end
   end

   // Line memory is read (above) before this write lands, giving the previous row's pixel.
   always_ff @(posedge clk) begin
      if (accept && !rst) mem_q[col_q] <= v2;
   end

endmodule

// File: tb/tb_line_buffer_win2x2.sv
// Directed, table-driven bench for line_buffer_win2x2 on a 4x4 image.
// Expected windows follow from pixel value p = row*4 + col.
module tb_line_buffer_win2x2;
   localparam int DW = 32;
   localparam int W  = 4;
   localparam int H  = 4;
`ifdef LINE_BUFFER_ZERO_PAD_EN
   localparam int EXP_PULSES = 16;
`else
   localparam int EXP_PULSES = 9;
`endif

   logic          clk = 1'b0;
   logic          rst, tstart, v0, v1, v3;
   logic [DW-1:0] v2;
   logic [DW-1:0] v4 [0:1][0:1];

   int compared   = 0;
   int mismatched = 0;
   int pulses;

   typedef struct {
      logic          v3;
      logic [DW-1:0] w00, w01, w10, w11;
   } vec_t;
   vec_t tbl [0:15];

   line_buffer_win2x2 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .tstart(tstart), .v0(v0), .v1(v1),
      .v2(v2), .v3(v3), .v4(v4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_win(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
      check({tag, " v4[0][0]"}, v4[0][0], a);
      check({tag, " v4[0][1]"}, v4[0][1], b);
      check({tag, " v4[1][0]"}, v4[1][0], c);
      check({tag, " v4[1][1]"}, v4[1][1], d);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " v1"}, {31'd0, v1}, 0);
      check({tag, " v3"}, {31'd0, v3}, 0);
      check_win(tag, 0, 0, 0, 0);
   endtask

   task automatic pulse_tstart();
      @(negedge clk);
      v0 = 1'b0;
      tstart = 1'b1;
      @(posedge clk);
      #1;
      tstart = 1'b0;
      check("v1 after tstart", {31'd0, v1}, 1);
   endtask

   task automatic send(input int p);
      string tag;
      tag = $sformatf("px%0d", p);
      @(negedge clk);
      v0 = 1'b1;
      v2 = p;
      check({tag, " v1 ready"}, {31'd0, v1}, 1);
      @(posedge clk);
      #1;
      if (v3) pulses++;
      check({tag, " v3"}, {31'd0, v3}, {31'd0, tbl[p].v3});
      if (tbl[p].v3) check_win(tag, tbl[p].w00, tbl[p].w01, tbl[p].w10, tbl[p].w11);
   endtask

   task automatic end_frame(input string tag);
      @(negedge clk);
      v0 = 1'b0;
      check({tag, " v1 after last pixel"}, {31'd0, v1}, 0);
      check({tag, " pulse count"}, pulses, EXP_PULSES);
   endtask

   initial begin
`ifdef LINE_BUFFER_ZERO_PAD_EN
      for (int p = 0; p < 16; p++) begin
         int r, c;
         r = p / W;
         c = p % W;
         tbl[p].v3  = 1'b1;
         tbl[p].w11 = p;
         tbl[p].w10 = (c > 0) ? p - 1 : 0;
         tbl[p].w01 = (r > 0) ? p - 4 : 0;
         tbl[p].w00 = (r > 0 && c > 0) ? p - 5 : 0;
      end
`else
      tbl[0]  = '{1'b0, 0, 0, 0, 0};
      tbl[1]  = '{1'b0, 0, 0, 0, 0};
      tbl[2]  = '{1'b0, 0, 0, 0, 0};
      tbl[3]  = '{1'b0, 0, 0, 0, 0};
      tbl[4]  = '{1'b0, 0, 0, 0, 0};
      tbl[5]  = '{1'b1, 0, 1, 4, 5};
      tbl[6]  = '{1'b1, 1, 2, 5, 6};
      tbl[7]  = '{1'b1, 2, 3, 6, 7};
      tbl[8]  = '{1'b0, 0, 0, 0, 0};
      tbl[9]  = '{1'b1, 4, 5, 8, 9};
      tbl[10] = '{1'b1, 5, 6, 9, 10};
      tbl[11] = '{1'b1, 6, 7, 10, 11};
      tbl[12] = '{1'b0, 0, 0, 0, 0};
      tbl[13] = '{1'b1, 8, 9, 12, 13};
      tbl[14] = '{1'b1, 9, 10, 13, 14};
      tbl[15] = '{1'b1, 10, 11, 14, 15};
`endif

      // Reset, then idle without tstart
      rst = 1'b1; tstart = 1'b0; v0 = 1'b0; v2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_zero($sformatf("idle%0d", i));
      end

      // Full uninterrupted frame
      pulse_tstart();
      pulses = 0;
      for (int p = 0; p < 16; p++) send(p);
      end_frame("frame1");

      // Frame with a 10-cycle v0 gap after pixel 9 (row 2, col 1)
      pulse_tstart();
      pulses = 0;
      for (int p = 0; p < 10; p++) send(p);
      @(negedge clk);
      v0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("gap%0d v3", i), {31'd0, v3}, 0);
         check_win($sformatf("gap%0d", i), 4, 5, 8, 9);
      end
      for (int p = 10; p < 16; p++) send(p);
      end_frame("frame2");

      // Reset mid-frame, then restart from row 0 col 0
      pulse_tstart();
      for (int p = 0; p < 7; p++) send(p);
      @(negedge clk);
      v0 = 1'b1;
      v2 = 7;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_zero("mid-frame reset");
      @(negedge clk);
      rst = 1'b0;
      v0 = 1'b0;
      @(posedge clk);
      #1;
      check_zero("post-reset idle");
      pulse_tstart();
      pulses = 0;
      for (int p = 0; p < 16; p++) send(p);
      end_frame("frame3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
